// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one line-wide memory port between the I-cache and the
//                D-cache. It serves one request at a time, holds it on the
//                memory side until memory completes, then returns the result
//                as a one-cycle pulse to the owning cache.
//                Build option ARB_DPRIO_EN: data side wins every tie
//                (default: round-robin via last owner).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 20,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_wack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              owner_d
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_owner_d;   // owner of the current/last transaction
    logic              r_last_d;    // owner of the last completed transaction
    logic              r_we;
    logic              r_cancel;    // I-side delivery cancelled by flush
    logic              r_mask_i;    // I just served: ignore its req this cycle
    logic              r_mask_d;    // D just served: ignore its req this cycle
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;

    logic              w_i_pend;
    logic              w_d_pend;
    logic              w_tie_d;
    logic              w_grant;
    logic              w_grant_d;

    assign w_i_pend = i_req & ~r_mask_i;
    assign w_d_pend = d_req & ~r_mask_d;

`ifdef ARB_DPRIO_EN
    assign w_tie_d = 1'b1;
`else
    assign w_tie_d = ~r_last_d;
`endif

    assign w_grant   = w_i_pend | w_d_pend;
    assign w_grant_d = (w_i_pend & w_d_pend) ? w_tie_d : w_d_pend;

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign owner_d   = r_owner_d;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

    // State register; reset drops any in-flight transaction at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic, memory request and the completion pulses.
    always_comb begin
        w_next  = r_state;
        mem_req = 1'b0;
        i_ready = 1'b0;
        d_ready = 1'b0;
        d_wack  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
                if (r_owner_d) begin
                    d_ready = ~r_we;
                    d_wack  = r_we;
                end else begin
                    i_ready = ~(r_cancel | flush);
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latching, return-data capture, owner history, mask and cancel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner_d <= 1'b0;
            r_last_d  <= 1'b1;
            r_we      <= 1'b0;
            r_cancel  <= 1'b0;
            r_mask_i  <= 1'b0;
            r_mask_d  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            // The mask lives for exactly the one IDLE cycle after DONE.
            r_mask_i <= 1'b0;
            r_mask_d <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_owner_d <= w_grant_d;
                        r_addr    <= w_grant_d ? d_addr : i_addr;
                        r_we      <= w_grant_d & d_we;
                        r_wdata   <= w_grant_d ? d_wdata : '0;
                    end
                end
                S_BUSY: begin
                    if (flush && !r_owner_d) begin
                        r_cancel <= 1'b1;
                    end
                    if (mem_ready) begin
                        if (!r_owner_d) begin
                            r_i_rdata <= mem_rdata;
                        end else if (!r_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                    end
                end
                S_DONE: begin
                    r_last_d <= r_owner_d;
                    r_mask_d <= r_owner_d;
                    r_mask_i <= ~r_owner_d;
                    r_cancel <= 1'b0;
                end
                default: begin
                    r_cancel <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
